// File: rtl/param_seq_alu.sv
// param_seq_alu: registered W-bit ALU with multi-cycle multiply and variable shift.
// Start/Busy/Done handshake; result and {Z,C,N,O} flags are written only on Done.
// Optional multiplier: define ALU_MUL_EN to include MULLO/MULHI and the MUL state.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | accepts Start; single-cycle ops complete from here
// MUL   | shift-add multiply, one multiplier bit per cycle (ALU_MUL_EN)
// SHIFT | LSLN/LSRN, one bit position per cycle
module param_seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [4:0]       FunSel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             WF,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUOut,
  output logic [3:0]       FlagsOut
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] alu_out_q;
  logic [3:0]       flags_q;
  logic             done_q;
  logic [WIDTH-1:0] work_q;
  logic [CW-1:0]    cnt_q;
  logic             wf_q;
  logic             shl_q;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] hi_q;
  logic             mul_hi_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi;
`endif

  logic [SHW-1:0]   sh_n;
  logic             is_mul;
  logic             is_shn;
  logic             cin;

  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic             sc_o;
  logic             sc_fw;
  logic [WIDTH:0]   sum_ext;

  logic [WIDTH-1:0] step_work;
  logic [WIDTH-1:0] fin_res;
  logic             fin_c;
  logic             fin_o;

  assign sh_n = B[SHW-1:0];
  assign cin  = flags_q[2];

`ifdef ALU_MUL_EN
  assign is_mul = (FunSel[4:1] == 4'b1000);
`else
  assign is_mul = 1'b0;
`endif
  // A shift by zero completes like a single-cycle op, so only n>0 enters SHIFT.
  assign is_shn = (FunSel[4:1] == 4'b1001) && (sh_n != '0);

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: leave MUL/SHIFT on the final iteration.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (is_mul)      state_d = S_MUL;
          else if (is_shn) state_d = S_SHIFT;
        end
      end
      S_MUL:   if (cnt_q == CW'(1)) state_d = S_IDLE;
      S_SHIFT: if (cnt_q == CW'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    Busy = (state_q != S_IDLE);
  end

  // Single-cycle result and flag candidates, computed straight from the inputs at Start.
  always_comb begin
    sc_res  = A;
    sc_c    = cin;
    sc_o    = flags_q[0];
    sc_fw   = 1'b1;
    sum_ext = '0;
    case (FunSel)
      5'b00000: sc_res = A;
      5'b00001: sc_res = B;
      5'b00010: sc_res = ~A;
      5'b00011: sc_res = ~B;
      5'b00100: begin
        sum_ext = {1'b0, A} + {1'b0, B};
        sc_res  = sum_ext[WIDTH-1:0];
        sc_c    = sum_ext[WIDTH];
        sc_o    = (A[WIDTH-1] == B[WIDTH-1]) && (sc_res[WIDTH-1] != A[WIDTH-1]);
      end
      5'b00101: begin
        sum_ext = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
        sc_res  = sum_ext[WIDTH-1:0];
        sc_c    = sum_ext[WIDTH];
        sc_o    = (A[WIDTH-1] == B[WIDTH-1]) && (sc_res[WIDTH-1] != A[WIDTH-1]);
      end
      5'b00110: begin
        sum_ext = {1'b0, A} - {1'b0, B};
        sc_res  = sum_ext[WIDTH-1:0];
        sc_c    = (A >= B);
        sc_o    = (A[WIDTH-1] != B[WIDTH-1]) && (sc_res[WIDTH-1] != A[WIDTH-1]);
      end
      5'b00111: sc_res = A & B;
      5'b01000: sc_res = A | B;
      5'b01001: sc_res = A ^ B;
      5'b01010: sc_res = ~(A & B);
      5'b01011: begin
        sc_res = {A[WIDTH-2:0], 1'b0};
        sc_c   = A[WIDTH-1];
      end
      5'b01100: begin
        sc_res = {1'b0, A[WIDTH-1:1]};
        sc_c   = A[0];
      end
      5'b01101: begin
        sc_res = {A[WIDTH-1], A[WIDTH-1:1]};
        sc_c   = A[0];
        sc_o   = 1'b0;
      end
      5'b01110: begin
        sc_res = {A[WIDTH-2:0], cin};
        sc_c   = A[WIDTH-1];
      end
      5'b01111: begin
        sc_res = {cin, A[WIDTH-1:1]};
        sc_c   = A[0];
      end
      // Zero-length LSLN/LSRN: pass A, carry untouched, Z/N still written.
      5'b10010, 5'b10011: sc_res = A;
      // Reserved codes (and MULLO/MULHI without the multiplier): pass A, no flag write.
      default: begin
        sc_res = A;
        sc_fw  = 1'b0;
      end
    endcase
  end

  // One iteration of the running multi-cycle op, plus the result/flags if it is the last.
  always_comb begin
    step_work = work_q;
    fin_res   = work_q;
    fin_c     = cin;
    fin_o     = flags_q[0];
`ifdef ALU_MUL_EN
    mul_sum = {1'b0, hi_q} + (work_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    step_hi = mul_sum[WIDTH:1];
`endif
    if (state_q == S_MUL) begin
`ifdef ALU_MUL_EN
      step_work = {mul_sum[0], work_q[WIDTH-1:1]};
      fin_res   = mul_hi_q ? step_hi : step_work;
      fin_c     = mul_hi_q ? 1'b0 : (step_hi != '0);
`endif
    end else if (shl_q) begin
      step_work = {work_q[WIDTH-2:0], 1'b0};
      fin_res   = step_work;
      fin_c     = work_q[WIDTH-1];
    end else begin
      step_work = {1'b0, work_q[WIDTH-1:1]};
      fin_res   = step_work;
      fin_c     = work_q[0];
    end
  end

  // Datapath registers: operand capture at Start, iteration, result and flag write on Done.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      alu_out_q <= '0;
      flags_q   <= 4'b0000;
      done_q    <= 1'b0;
      work_q    <= '0;
      cnt_q     <= '0;
      wf_q      <= 1'b0;
      shl_q     <= 1'b0;
`ifdef ALU_MUL_EN
      a_q       <= '0;
      hi_q      <= '0;
      mul_hi_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            wf_q <= WF;
            if (is_mul) begin
`ifdef ALU_MUL_EN
              a_q      <= A;
              work_q   <= B;
              hi_q     <= '0;
              mul_hi_q <= FunSel[0];
              cnt_q    <= CW'(WIDTH);
`endif
            end else if (is_shn) begin
              work_q <= A;
              shl_q  <= ~FunSel[0];
              cnt_q  <= CW'(sh_n);
            end else begin
              alu_out_q <= sc_res;
              done_q    <= 1'b1;
              if (WF && sc_fw)
                flags_q <= {(sc_res == '0), sc_c, sc_res[WIDTH-1], sc_o};
            end
          end
        end
        S_MUL, S_SHIFT: begin
          work_q <= step_work;
`ifdef ALU_MUL_EN
          hi_q   <= step_hi;
`endif
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            alu_out_q <= fin_res;
            done_q    <= 1'b1;
            if (wf_q)
              flags_q <= {(fin_res == '0), fin_c, fin_res[WIDTH-1], fin_o};
          end
        end
        default: ;
      endcase
    end
  end

  assign Done     = done_q;
  assign ALUOut   = alu_out_q;
  assign FlagsOut = flags_q;

endmodule

// File: tb/tb_param_seq_alu.sv
// Scoreboard bench for param_seq_alu: directed cases followed by randomized ops.
// Expected results come from a plain-arithmetic reference model; a monitor checks
// every Done, the Busy window and the Done timing.
module tb_param_seq_alu;

  localparam int W   = 16;
  localparam int SHW = $clog2(W);

  logic         Clock  = 1'b0;
  logic         Reset  = 1'b1;
  logic         Start  = 1'b0;
  logic [4:0]   FunSel = '0;
  logic [W-1:0] A      = '0;
  logic [W-1:0] B      = '0;
  logic         WF     = 1'b0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] ALUOut;
  logic [3:0]   FlagsOut;

  param_seq_alu #(.WIDTH(W)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .FunSel   (FunSel),
    .A        (A),
    .B        (B),
    .WF       (WF),
    .Busy     (Busy),
    .Done     (Done),
    .ALUOut   (ALUOut),
    .FlagsOut (FlagsOut)
  );

  always #5 Clock = ~Clock;

  longint cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   fl;
    longint       due;
    int           id;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [3:0] m_flags  = 4'b0000;
  longint     free_cyc = 0;
  longint     busy_lo  = 1;
  longint     busy_hi  = 0;
  int         n_cmp    = 0;
  int         n_bad    = 0;
  int         op_id    = 0;
  bit         mon_en   = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: result, flag update and latency from the op rules, in plain arithmetic.
  function automatic void model(input logic [4:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic wf, inout logic [3:0] fl,
                                output logic [W-1:0] r, output int lat);
    longint ua, ub, mask, half, full, sa, sbv, s, p;
    int     n;
    bit     c, o, wr, cin;
    ua   = a;
    ub   = b;
    mask = (longint'(1) << W) - 1;
    half = longint'(1) << (W - 1);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sbv  = (ub >= half) ? ub - 2 * half : ub;
    cin  = fl[2];
    c    = fl[2];
    o    = fl[0];
    wr   = 1'b1;
    lat  = 1;
    n    = int'(ub % (longint'(1) << SHW));
    full = ua;
    case (fs)
      5'd0:  full = ua;
      5'd1:  full = ub;
      5'd2:  full = ~ua & mask;
      5'd3:  full = ~ub & mask;
      5'd4: begin
        full = ua + ub;
        c    = (full > mask);
        s    = sa + sbv;
        o    = (s >= half) || (s < -half);
      end
      5'd5: begin
        full = ua + ub + longint'(cin);
        c    = (full > mask);
        s    = sa + sbv + longint'(cin);
        o    = (s >= half) || (s < -half);
      end
      5'd6: begin
        full = (ua - ub) & mask;
        c    = (ua >= ub);
        s    = sa - sbv;
        o    = (s >= half) || (s < -half);
      end
      5'd7:  full = ua & ub;
      5'd8:  full = ua | ub;
      5'd9:  full = ua ^ ub;
      5'd10: full = ~(ua & ub) & mask;
      5'd11: begin full = ua * 2; c = (ua >= half); end
      5'd12: begin full = ua / 2; c = (ua % 2) != 0; end
      5'd13: begin full = (ua / 2) | (ua & half); c = (ua % 2) != 0; o = 1'b0; end
      5'd14: begin full = ua * 2 + longint'(cin); c = (ua >= half); end
      5'd15: begin full = ua / 2 + (cin ? half : 0); c = (ua % 2) != 0; end
`ifdef ALU_MUL_EN
      5'd16: begin p = ua * ub; full = p & mask; c = (p >> W) != 0; lat = W + 1; end
      5'd17: begin p = ua * ub; full = p >> W;   c = 1'b0;          lat = W + 1; end
`endif
      5'd18: begin
        if (n != 0) begin
          full = ua << n;
          c    = ((ua >> (W - n)) & 1) != 0;
          lat  = n + 1;
        end
      end
      5'd19: begin
        if (n != 0) begin
          full = ua >> n;
          c    = ((ua >> (n - 1)) & 1) != 0;
          lat  = n + 1;
        end
      end
      default: begin full = ua; wr = 1'b0; end
    endcase
    full = full & mask;
    r    = full[W-1:0];
    if (wf && wr) fl = {(r == '0), c, r[W-1], o};
  endfunction

  // Issue one op as soon as the model says the block is idle, then scramble the inputs.
  task automatic issue(input logic [4:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic wf);
    exp_t         e;
    int           lat;
    logic [W-1:0] r;
    while (cyc < free_cyc) @(negedge Clock);
    Start  = 1'b1;
    FunSel = fs;
    A      = a;
    B      = b;
    WF     = wf;
    model(fs, a, b, wf, m_flags, r, lat);
    e.res = r;
    e.fl  = m_flags;
    e.due = cyc + lat;
    e.id  = op_id;
    op_id++;
    sb.push_back(e);
    free_cyc = e.due;
    if (lat > 1) begin
      busy_lo = cyc + 1;
      busy_hi = e.due - 1;
    end
    @(negedge Clock);
    Start  = 1'b0;
    FunSel = 5'($urandom);
    A      = W'($urandom);
    B      = W'($urandom);
    WF     = 1'($urandom);
  endtask

  // Monitor: Busy window every cycle, and each Done against the scoreboard head.
  always @(negedge Clock) begin
    if (mon_en) begin
      chk("busy", {63'd0, Busy}, {63'd0, (cyc >= busy_lo) && (cyc <= busy_hi)});
      if (Done === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_done: Done=1 but no op pending (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk($sformatf("aluout op%0d", mon_e.id), {48'd0, ALUOut}, {48'd0, mon_e.res});
          chk($sformatf("flags op%0d", mon_e.id), {60'd0, FlagsOut}, {60'd0, mon_e.fl});
          chk($sformatf("done_cycle op%0d", mon_e.id), cyc, mon_e.due);
        end
      end else if (sb.size() != 0 && cyc >= sb[0].due) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missing_done op%0d: Done=%b at cycle %0d, expected 1", sb[0].id, Done, cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]   fs;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    chk("reset_aluout", {48'd0, ALUOut}, 64'd0);
    chk("reset_flags", {60'd0, FlagsOut}, 64'd0);
    chk("reset_busy", {63'd0, Busy}, 64'd0);
    chk("reset_done", {63'd0, Done}, 64'd0);
    free_cyc = cyc;
    mon_en   = 1'b1;

    // Directed cases.
    issue(5'b00100, 16'h7FFF, 16'h0001, 1'b1);
    issue(5'b00110, 16'h0005, 16'h0005, 1'b1);
    issue(5'b00110, 16'h0005, 16'h0005, 1'b0);
    issue(5'b01110, 16'h8000, 16'h0000, 1'b1);
    issue(5'b01111, 16'h0002, 16'h0000, 1'b1);
    issue(5'b10000, 16'h1234, 16'h0100, 1'b1);
    issue(5'b10001, 16'h1234, 16'h0100, 1'b1);
    issue(5'b10011, 16'hF000, 16'h0004, 1'b1);
    // Start pulse while busy must be ignored.
    Start  = 1'b1;
    FunSel = 5'b00000;
    A      = 16'h1234;
    WF     = 1'b1;
    @(negedge Clock);
    Start  = 1'b0;
    issue(5'b11000, 16'hABCD, 16'h0000, 1'b1);
    issue(5'b10010, 16'h00F1, 16'h0000, 1'b1);
    for (int i = 0; i < 4; i++) issue(5'b00000, W'($urandom), W'($urandom), 1'b1);

    // Reset in the second busy cycle of a shift: no Done, outputs back to reset values.
    issue(5'b10011, 16'hF000, 16'h0004, 1'b0);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    sb.delete();
    m_flags = 4'b0000;
    busy_lo = 1;
    busy_hi = 0;
    @(negedge Clock);
    Reset    = 1'b0;
    free_cyc = cyc;
    chk("midrst_aluout", {48'd0, ALUOut}, 64'd0);
    chk("midrst_flags", {60'd0, FlagsOut}, 64'd0);
    chk("midrst_busy", {63'd0, Busy}, 64'd0);
    chk("midrst_done", {63'd0, Done}, 64'd0);
    repeat (6) @(negedge Clock);

    // Randomized ops with random idle gaps.
    for (int i = 0; i < 300; i++) begin
      fs = 5'($urandom);
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 3) == 0) ra = W'($urandom_range(0, 3)) << (W - 2);
      if ($urandom_range(0, 3) == 0) rb = ra;
      issue(fs, ra, rb, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge Clock);
    end

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge Clock);
    repeat (3) @(negedge Clock);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d ops still pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
